// File: rtl/res_buf_ctrl.sv
// Result buffer sequencer: round-robin fill from PE streams, then in-order drain.
module res_buf_ctrl #(
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 26,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_DEPTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         buf_wr_en,
  output logic [ADDR_WIDTH-1:0]        buf_wr_addr,
  output logic [BIT_DEPTH-1:0]         buf_data_in,
  input  logic [BIT_DEPTH-1:0]         buf_data_out,
  output logic                         out_valid,
  output logic [BIT_DEPTH-1:0]         out_data,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [RR_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic                  gnt_any;
  logic [RR_W-1:0]       gnt_idx;
  logic [RR_W-1:0]       srch_idx;

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    srch_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      srch_idx = RR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && req_valid[srch_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = srch_idx;
      end
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next-state, pointer updates and phase-dependent outputs
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    rr_ptr_nxt  = rr_ptr;
    req_ready   = '0;
    buf_wr_en   = 1'b0;
    buf_wr_addr = '0;
    buf_data_in = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          wr_ptr_nxt = '0;
          rr_ptr_nxt = '0;
          state_nxt  = S_FILL;
        end
      end
      S_FILL: begin
        busy        = 1'b1;
        buf_wr_addr = wr_ptr;
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          buf_wr_en          = 1'b1;
          buf_data_in        = req_data[32'(gnt_idx) * BIT_DEPTH +: BIT_DEPTH];
          rr_ptr_nxt         = RR_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
          // Last entry written: pointer stays in range, drain starts from 0
          if (wr_ptr == LAST_ADDR) begin
            rd_ptr_nxt = '0;
            state_nxt  = S_DRAIN;
          end else begin
            wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        busy        = 1'b1;
        buf_wr_addr = rd_ptr;
        out_valid   = 1'b1;
        out_data    = buf_data_out;
        if (out_ready) begin
          if (rd_ptr == LAST_ADDR) begin
            state_nxt = S_DONE;
          end else begin
            rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_res_buf_ctrl.sv
// Bench for res_buf_ctrl: randomized fill/drain runs against a queue-based reference model.
module tb_res_buf_ctrl;

  localparam int BW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 26;
  localparam int NREQ  = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*BW-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             buf_wr_en;
  logic [AW-1:0]    buf_wr_addr;
  logic [BW-1:0]    buf_data_in;
  logic [BW-1:0]    buf_data_out;
  logic             out_valid;
  logic [BW-1:0]    out_data;
  logic             out_ready;
  logic             busy;
  logic             done;

  res_buf_ctrl #(
    .BIT_DEPTH (BW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .NUM_REQ   (NREQ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_data_in (buf_data_in),
    .buf_data_out(buf_data_out),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  // Single-port buffer with combinational read at the shared address
  logic [BW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (buf_wr_en) mem[buf_wr_addr] <= buf_data_in;
  assign buf_data_out = mem[buf_wr_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [BW-1:0]   data;
    logic [NREQ-1:0] ready;
  } fexp_t;

  fexp_t         fill_q[$];
  logic [BW-1:0] rd_q[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  int            done_cnt = 0;
  bit            stall_prev = 0;
  logic [BW-1:0] held_data;

  // Reference model state
  int            mdl_cnt;
  int            mdl_rr;
  logic [BW-1:0] mdl_mem [DEPTH];
  logic [BW-1:0] cur [NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] next_word(input int mode, input int i);
    if (mode == 0) return BW'(8'h10 + i);
    if (mode == 1) return 8'hA5;
    return BW'($urandom);
  endfunction

  function automatic bit drain_rdy(input int mode, input int k);
    if (mode == 1) return (k % 3) == 0;
    if (mode == 3) return 1'($urandom);
    return 1'b1;
  endfunction

  // Drive one FILL cycle and record the expected write (or idle cycle)
  task automatic drive_fill(input int mode, input logic [NREQ-1:0] v);
    int    g;
    fexp_t e;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) req_data[i*BW +: BW] = cur[i];
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && v[(mdl_rr + k) % NREQ]) g = (mdl_rr + k) % NREQ;
    end
    e.we = 1'b0; e.addr = '0; e.data = '0; e.ready = '0;
    if (g >= 0) begin
      e.we    = 1'b1;
      e.addr  = AW'(mdl_cnt);
      e.data  = cur[g];
      e.ready = NREQ'(1 << g);
      mdl_mem[mdl_cnt] = cur[g];
      mdl_cnt++;
      mdl_rr = (g + 1) % NREQ;
      cur[g] = next_word(mode, g);
    end
    fill_q.push_back(e);
  endtask

  // Monitor: compare fill expectations and drain stream at the falling edge
  always @(negedge clk) begin
    fexp_t e;
    if (fill_q.size() > 0) begin
      e = fill_q.pop_front();
      chk("fill_wr_en", 32'(buf_wr_en), 32'(e.we));
      chk("fill_ready", 32'(req_ready), 32'(e.ready));
      if (e.we) begin
        chk("fill_addr", 32'(buf_wr_addr), 32'(e.addr));
        chk("fill_data", 32'(buf_data_in), 32'(e.data));
      end
    end
    if (out_valid) begin
      if (stall_prev) chk("drain_hold", 32'(out_data), 32'(held_data));
      if (out_ready) begin
        if (rd_q.size() == 0) begin
          chk("drain_extra", 32'(acc_cnt), 32'(DEPTH - 1));
        end else begin
          chk("drain_data", 32'(out_data), 32'(rd_q.pop_front()));
          chk("drain_addr", 32'(buf_wr_addr), 32'(acc_cnt));
        end
        acc_cnt++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        held_data  = out_data;
      end
    end else begin
      stall_prev = 1'b0;
    end
    if (done) done_cnt++;
  end

  // One complete run; called at a falling edge while the DUT is in IDLE
  task automatic run(input int mode, input bit hold_after);
    int              cyc, gaps, k;
    logic [NREQ-1:0] v;
    mdl_cnt = 0; mdl_rr = 0; gaps = 0; acc_cnt = 0; done_cnt = 0;
    for (int i = 0; i < NREQ; i++) cur[i] = next_word(mode, i);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (mdl_cnt < DEPTH && cyc < 300) begin
      if (mode == 1) v = 4'b0100;
      else if (mode == 3) v = NREQ'($urandom);
      else v = '1;
      if (mode == 2 && mdl_cnt == 6 && gaps < 3) begin
        v = '0;
        gaps++;
      end
      if (mode == 3) start = 1'($urandom);
      drive_fill(mode, v);
      @(posedge clk); #1;
      cyc++;
    end
    if (mdl_cnt < DEPTH) chk("fill_timeout", 32'(mdl_cnt), 32'(DEPTH));
    if (mode == 1) chk("fill_cycles", 32'(cyc), 32'(DEPTH));
    req_valid = '0;
    for (int a = 0; a < DEPTH; a++) rd_q.push_back(mdl_mem[a]);
    out_ready = drain_rdy(mode, 0);
    @(negedge clk);
    chk("fill_q_empty", 32'(fill_q.size()), 32'd0);
    chk("drain_first_valid", 32'(out_valid), 32'd1);
    chk("drain_busy", 32'(busy), 32'd1);
    k = 1; cyc = 0;
    forever begin
      @(posedge clk);
      if (acc_cnt >= DEPTH || cyc >= 400) break;
      #1;
      out_ready = drain_rdy(mode, k);
      if (mode == 3) start = 1'($urandom);
      k++; cyc++;
    end
    if (acc_cnt < DEPTH) chk("drain_timeout", 32'(acc_cnt), 32'(DEPTH));
    #1;
    out_ready = 1'b0;
    start = hold_after;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("done_low", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
  endtask

  // Abort mid-FILL at wr_ptr=7 with an asynchronous reset
  task automatic reset_mid_fill();
    mdl_cnt = 0; mdl_rr = 0;
    for (int i = 0; i < NREQ; i++) cur[i] = next_word(0, i);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive_fill(0, '1);
      @(posedge clk); #1;
    end
    req_valid = '1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({buf_wr_addr, buf_data_in, out_valid, out_data, done}), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wr_en", 32'(buf_wr_en), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", 32'({req_ready, buf_wr_en, buf_wr_addr, out_valid, done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 32'(busy), 32'd0);
    run(0, 1'b0);
    run(1, 1'b1);
    run(2, 1'b0);
    for (int r = 0; r < 3; r++) run(3, 1'b0);
    reset_mid_fill();
    run(0, 1'b0);
    run(3, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
